// File: rtl/divider_8_pkg.sv
// Shared types and constants for the divider_8 job sequencer.
package divider_8_pkg;

  localparam int unsigned DATA_W                 = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 4096;
  localparam logic [DATA_W-1:0] DIV0_QUOTIENT    = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_DONE,
    ACK,
    RESP
  } req_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
    logic              div0;
    logic              timeout;
  } rsp_t;

endpackage

// File: rtl/divider_8_watchdog.sv
// Handshake watchdog: cycle counter with clear, enable and a terminal-count flag.
module divider_8_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Terminal count forces a state exit, so the counter never wraps.
  assign tc_c = en && (cnt == TC_VAL);

endmodule

// File: rtl/divider_8_requester.sv
// Job sequencer driving the divider's Start/Done/Ack handshake from a
// valid/ready request port and returning results on a valid/ready response port.
module divider_8_requester
  import divider_8_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              ClkPort,
  input  logic              Reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_x,
  input  logic [DATA_W-1:0] req_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_q,
  output logic [DATA_W-1:0] rsp_r,
  output logic              rsp_div0,
  output logic              rsp_timeout,
  output logic [DATA_W-1:0] Xin,
  output logic [DATA_W-1:0] Yin,
  output logic              Start,
  output logic              Ack,
  input  logic              Done,
  input  logic              Qi,
  input  logic              Qc,
  input  logic              Qd,
  input  logic [DATA_W-1:0] Quotient,
  input  logic [DATA_W-1:0] Remainder
);

  req_state_e        state, state_n;
  rsp_t              rsp, rsp_n;
  logic [DATA_W-1:0] xin_n, yin_n;
  logic              wd_clr, wd_en, wd_tc_c;
  logic              done_ok, abort;

  // A done sample only counts when the divider reports a clean Qd state.
  assign done_ok = Done && Qd && !Qi && !Qc;
  assign wd_en   = (state == START) || (state == WAIT_DONE) || (state == ACK);
  assign wd_clr  = (state_n != state);

  divider_8_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk  (ClkPort),
    .rst_n(Reset_n),
    .clr  (wd_clr),
    .en   (wd_en),
    .tc_c (wd_tc_c)
  );

  // Next-state, operand and response computation.
  always_comb begin
    state_n = state;
    rsp_n   = rsp;
    xin_n   = Xin;
    yin_n   = Yin;
    abort   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          xin_n = req_x;
          yin_n = req_y;
          rsp_n = '0;
          if (req_y == '0) begin
            state_n    = RESP;
            rsp_n.div0 = 1'b1;
            rsp_n.q    = DIV0_QUOTIENT;
            rsp_n.r    = req_x;
          end else begin
            state_n = START;
          end
        end
      end
      START: begin
        if (!Qi)          state_n = WAIT_DONE;
        else if (wd_tc_c) abort   = 1'b1;
      end
      WAIT_DONE: begin
        if (done_ok) begin
          state_n = ACK;
          rsp_n.q = Quotient;
          rsp_n.r = Remainder;
        end else if (wd_tc_c) begin
          abort = 1'b1;
        end
      end
      ACK: begin
        if (Qi)           state_n = RESP;
        else if (wd_tc_c) abort   = 1'b1;
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n       = RESP;
      rsp_n         = '0;
      rsp_n.timeout = 1'b1;
    end
  end

  // State and all outputs registered; handshake outputs follow the next state.
  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      rsp       <= '0;
      Xin       <= '0;
      Yin       <= '0;
      Start     <= 1'b0;
      Ack       <= 1'b0;
      rsp_valid <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      state     <= state_n;
      rsp       <= rsp_n;
      Xin       <= xin_n;
      Yin       <= yin_n;
      Start     <= (state_n == START);
      Ack       <= (state_n == ACK);
      rsp_valid <= (state_n == RESP);
      req_ready <= (state_n == IDLE) && Qi;
    end
  end

  assign rsp_q       = rsp.q;
  assign rsp_r       = rsp.r;
  assign rsp_div0    = rsp.div0;
  assign rsp_timeout = rsp.timeout;

endmodule

// File: tb/tb_divider_8_requester.sv
// Bench for divider_8_requester with a behavioural divider and reference results.
module tb_divider_8_requester;

  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       div_rst_n = 1'b0;
  logic       req_valid = 1'b0, req_ready;
  logic [7:0] req_x = '0, req_y = '0;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [7:0] rsp_q, rsp_r, Xin, Yin, quot, rem;
  logic       rsp_div0, rsp_timeout, Start, Ack, Done, Qi, Qc, Qd;
  logic [1:0] dst;
  int         dcnt;
  bit         hang = 1'b0;
  int         vectors = 0, miscompares = 0;

  typedef struct {
    logic [17:0] got;
    int          lat;
    int          wcyc;
    bit          start_seen, stable, rdy_in_resp, rdy_after, ok;
    logic [1:0]  sa_rsp;
  } job_res_t;

  always #5 clk = ~clk;

  divider_8_requester #(.TIMEOUT_CYCLES(TO)) dut (
    .ClkPort(clk), .Reset_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q), .rsp_r(rsp_r),
    .rsp_div0(rsp_div0), .rsp_timeout(rsp_timeout),
    .Xin(Xin), .Yin(Yin), .Start(Start), .Ack(Ack),
    .Done(Done), .Qi(Qi), .Qc(Qc), .Qd(Qd), .Quotient(quot), .Remainder(rem)
  );

  // Divider: initial -> compute (random latency, garbage results) -> done, Ack returns it.
  always @(posedge clk or negedge div_rst_n) begin
    if (!div_rst_n) begin
      dst <= 2'd0; dcnt <= 0; quot <= '0; rem <= '0;
    end else begin
      case (dst)
        2'd0: if (Start) begin dst <= 2'd1; dcnt <= int'($urandom_range(6, 0)); end
        2'd1: begin
          quot <= 8'($urandom); rem <= 8'($urandom);
          if (!hang) begin
            if (dcnt == 0) begin
              dst <= 2'd2;
              quot <= (Yin == 8'd0) ? 8'hFF : 8'(Xin / Yin);
              rem  <= (Yin == 8'd0) ? Xin : 8'(Xin % Yin);
            end else dcnt <= dcnt - 1;
          end
        end
        2'd2: if (Ack) dst <= 2'd0;
        default: dst <= 2'd0;
      endcase
    end
  end
  assign Qi = (dst == 2'd0);
  assign Qc = (dst == 2'd1);
  assign Qd = (dst == 2'd2);
  assign Done = (dst == 2'd2);

  // Expected {q, r, div0, timeout} for a completed job.
  function automatic logic [17:0] ref_rsp(input logic [7:0] x, input logic [7:0] y);
    if (y == 8'd0) return {8'hFF, x, 1'b1, 1'b0};
    return {8'(x / y), 8'(x % y), 1'b0, 1'b0};
  endfunction

  task automatic run_job(input logic [7:0] x, input logic [7:0] y, input int bp, output job_res_t res);
    int guard = 0;
    res = '{got: '0, lat: 0, wcyc: 0, start_seen: 0, stable: 1, rdy_in_resp: 0,
            rdy_after: 0, ok: 1, sa_rsp: 2'b00};
    req_x = x; req_y = y; req_valid = 1'b1;
    while (!req_ready && guard < 200) begin @(negedge clk); guard++; end
    if (!req_ready) begin res.ok = 0; req_valid = 1'b0; return; end
    @(negedge clk);
    req_valid = 1'b0;
    forever begin
      res.lat++;
      if (Start && Ack) res.ok = 0;
      if (Start) res.start_seen = 1;
      else if (res.start_seen && !rsp_valid) res.wcyc++;
      if (rsp_valid || res.lat > 200) break;
      @(negedge clk);
    end
    if (!rsp_valid) begin res.ok = 0; return; end
    res.got = {rsp_q, rsp_r, rsp_div0, rsp_timeout};
    res.sa_rsp = {Start, Ack};
    for (int i = 0; i < bp; i++) begin
      if (req_ready) res.rdy_in_resp = 1;
      @(negedge clk);
      if (!rsp_valid || res.got !== {rsp_q, rsp_r, rsp_div0, rsp_timeout}) res.stable = 0;
    end
    if (req_ready) res.rdy_in_resp = 1;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    res.rdy_after = req_ready;
    if (rsp_valid) res.ok = 0;
  endtask

  task automatic test_reset();
    vectors++;
    if ({Xin, Yin, rsp_q, rsp_r, Start, Ack, rsp_valid, rsp_div0, rsp_timeout, req_ready} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: got Xin=%h Yin=%h q=%h r=%h S=%b A=%b v=%b d0=%b to=%b rdy=%b, expected all 0",
               Xin, Yin, rsp_q, rsp_r, Start, Ack, rsp_valid, rsp_div0, rsp_timeout, req_ready);
    end
    rst_n = 1'b1; div_rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL ready_after_reset: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_normal();
    job_res_t res;
    run_job(8'd200, 8'd7, 0, res);
    vectors++;
    if (res.ok !== 1'b1 || res.got !== {8'd28, 8'd4, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL normal_200_7: got %h ok=%b expected %h ok=1", res.got, res.ok, {8'd28, 8'd4, 2'b00});
    end
    vectors++;
    if ({res.start_seen, res.sa_rsp, Xin, Yin} !== {1'b1, 2'b00, 8'd200, 8'd7}) begin
      miscompares++;
      $display("FAIL normal_handshake: got start_seen=%b SA=%b Xin=%0d Yin=%0d expected 1 00 200 7",
               res.start_seen, res.sa_rsp, Xin, Yin);
    end
  endtask

  task automatic test_edges();
    logic [7:0] xs [3] = '{8'd5, 8'd255, 8'd9};
    logic [7:0] ys [3] = '{8'd9, 8'd1, 8'd9};
    job_res_t res;
    for (int i = 0; i < 3; i++) begin
      run_job(xs[i], ys[i], 1, res);
      vectors++;
      if (res.ok !== 1'b1 || res.got !== ref_rsp(xs[i], ys[i])) begin
        miscompares++;
        $display("FAIL edge_%0d_%0d: got %h ok=%b expected %h", xs[i], ys[i], res.got, res.ok, ref_rsp(xs[i], ys[i]));
      end
    end
  endtask

  task automatic test_div0();
    job_res_t res;
    run_job(8'd37, 8'd0, 0, res);
    vectors++;
    if (res.ok !== 1'b1 || res.got !== {8'hFF, 8'd37, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL div0_result: got %h ok=%b expected %h", res.got, res.ok, {8'hFF, 8'd37, 2'b10});
    end
    vectors++;
    if (res.lat !== 1 || res.start_seen !== 1'b0) begin
      miscompares++; $display("FAIL div0_timing: got lat=%0d start_seen=%b expected lat=1 start_seen=0", res.lat, res.start_seen);
    end
  endtask

  task automatic test_backpressure();
    job_res_t res;
    run_job(8'd123, 8'd10, 10, res);
    vectors++;
    if (res.ok !== 1'b1 || res.got !== ref_rsp(8'd123, 8'd10) || res.stable !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure_data: got %h ok=%b stable=%b expected %h ok=1 stable=1", res.got, res.ok, res.stable, ref_rsp(8'd123, 8'd10));
    end
    vectors++;
    if ({res.rdy_in_resp, res.rdy_after} !== 2'b01) begin
      miscompares++; $display("FAIL backpressure_ready: got in_resp=%b after=%b expected 0 1", res.rdy_in_resp, res.rdy_after);
    end
  endtask

  task automatic test_back_to_back();
    job_res_t r1, r2;
    run_job(8'd77, 8'd6, 0, r1);
    run_job(8'd64, 8'd8, 0, r2);
    vectors++;
    if (r1.ok !== 1'b1 || r2.ok !== 1'b1 || r1.got !== ref_rsp(8'd77, 8'd6) || r2.got !== ref_rsp(8'd64, 8'd8)) begin
      miscompares++;
      $display("FAIL back_to_back: got %h/%h ok=%b%b expected %h/%h", r1.got, r2.got, r1.ok, r2.ok,
               ref_rsp(8'd77, 8'd6), ref_rsp(8'd64, 8'd8));
    end
    vectors++;
    if ({r1.rdy_in_resp, r1.rdy_after, r2.rdy_in_resp} !== 3'b010) begin
      miscompares++; $display("FAIL back_to_back_ready: got %b%b%b expected 010", r1.rdy_in_resp, r1.rdy_after, r2.rdy_in_resp);
    end
  endtask

  task automatic test_random();
    job_res_t res;
    logic [7:0] x, y;
    for (int i = 0; i < 24; i++) begin
      x = 8'($urandom);
      y = ($urandom_range(5, 0) == 0) ? 8'd0 : 8'($urandom);
      run_job(x, y, int'($urandom_range(3, 0)), res);
      vectors++;
      if (res.ok !== 1'b1 || res.got !== ref_rsp(x, y) || res.stable !== 1'b1) begin
        miscompares++;
        $display("FAIL random_%0d_%0d: got %h ok=%b stable=%b expected %h", x, y, res.got, res.ok, res.stable, ref_rsp(x, y));
      end
    end
  endtask

  task automatic test_timeout();
    job_res_t res;
    bit rdy_seen = 0;
    int guard = 0;
    hang = 1'b1;
    run_job(8'd50, 8'd5, 0, res);
    vectors++;
    if (res.ok !== 1'b1 || res.got !== {16'h0000, 1'b0, 1'b1} || res.sa_rsp !== 2'b00) begin
      miscompares++; $display("FAIL timeout_result: got %h ok=%b SA=%b expected 00001 ok=1 SA=00", res.got, res.ok, res.sa_rsp);
    end
    vectors++;
    if (res.wcyc !== int'(TO)) begin
      miscompares++; $display("FAIL timeout_cycles: got %0d expected %0d", res.wcyc, TO);
    end
    for (int i = 0; i < 5; i++) begin
      if (req_ready) rdy_seen = 1;
      @(negedge clk);
    end
    vectors++;
    if ({res.rdy_after, rdy_seen} !== 2'b00) begin
      miscompares++; $display("FAIL timeout_ready_held: got after=%b later=%b expected 0 0", res.rdy_after, rdy_seen);
    end
    div_rst_n = 1'b0;
    @(negedge clk);
    div_rst_n = 1'b1; hang = 1'b0;
    while (!req_ready && guard < 10) begin @(negedge clk); guard++; end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL timeout_recover: got req_ready=%b expected 1", req_ready);
    end
  endtask

  task automatic test_reset_mid();
    job_res_t res;
    int guard = 0;
    hang = 1'b1;
    req_x = 8'd100; req_y = 8'd3; req_valid = 1'b1;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    vectors++;
    if ({Start, Ack, rsp_valid, Xin, Yin} !== {3'b000, 8'd100, 8'd3}) begin
      miscompares++; $display("FAIL mid_wait_done: got S=%b A=%b v=%b Xin=%0d Yin=%0d expected 0 0 0 100 3",
                              Start, Ack, rsp_valid, Xin, Yin);
    end
    #2;
    rst_n = 1'b0; div_rst_n = 1'b0;
    #1;
    vectors++;
    if ({Xin, Yin, rsp_q, rsp_r, Start, Ack, rsp_valid, rsp_div0, rsp_timeout, req_ready} !== '0) begin
      miscompares++; $display("FAIL async_reset: got Xin=%h Yin=%h S=%b A=%b v=%b rdy=%b expected all 0",
                              Xin, Yin, Start, Ack, rsp_valid, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1; div_rst_n = 1'b1; hang = 1'b0;
    @(negedge clk);
    run_job(8'd100, 8'd3, 1, res);
    vectors++;
    if (res.ok !== 1'b1 || res.got !== {8'd33, 8'd1, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL after_reset_100_3: got %h ok=%b expected %h", res.got, res.ok, {8'd33, 8'd1, 2'b00});
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_normal();
    test_edges();
    test_div0();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
